// File: rtl/alu_md_control.sv
// alu_md_control
//   ALU control decoder plus an iterative M-extension unit (MUL/MULH/MULHSU/
//   MULHU/DIV/DIVU/REM/REMU). Multiplication is a shift-add over operand
//   magnitudes and division is a restoring divide. Each produces one bit per
//   cycle for WIDTH cycles. Divide-by-zero and signed overflow finish after a
//   single DIV cycle.
//
// Ports
//   CLK, RESET          clock, asynchronous active-high reset
//   ALUOp[3:0]          operation class from main control
//   bits[3:0]           {instr[30], instr[14:12]}
//   m_sel               instr[25], selects M-ops when ALUOp = 0000
//   start               launch request for an M-op on A/B
//   A, B [WIDTH-1:0]    rs1 / rs2 operands
//   salida_ALUcontrol   combinational ALU operation code
//   stall               pipeline hold request (combinational)
//   busy                M-unit occupied (MUL, DIV, DONE)
//   done                one-cycle result-valid pulse
//   result[WIDTH-1:0]   M-op result, held until the next completion
module alu_md_control #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       ALUOp,
    input  logic [3:0]       bits,
    input  logic             m_sel,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [3:0]       salida_ALUcontrol,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t r_state, w_next;

    // ------------------------------------------------------------------
    // ALU control decode
    // ------------------------------------------------------------------
    logic w_mop;
    assign w_mop = (ALUOp == 4'b0000) && m_sel;

    always_comb begin
        salida_ALUcontrol = 4'b0000;
        if (!w_mop) begin
            case (ALUOp)
                4'b0000: begin
                    case (bits)
                        4'b0000: salida_ALUcontrol = 4'b0000;
                        4'b1000: salida_ALUcontrol = 4'b0111;
                        4'b0001: salida_ALUcontrol = 4'b1000;
                        4'b0010: salida_ALUcontrol = 4'b0100;
                        4'b0011: salida_ALUcontrol = 4'b0100;
                        4'b0100: salida_ALUcontrol = 4'b1001;
                        4'b0101: salida_ALUcontrol = 4'b1010;
                        4'b1101: salida_ALUcontrol = 4'b1110;
                        4'b0110: salida_ALUcontrol = 4'b0001;
                        4'b0111: salida_ALUcontrol = 4'b0010;
                        default: salida_ALUcontrol = 4'b0000;
                    endcase
                end
                4'b1100: begin
                    // Immediate forms: instr[30] only distinguishes SRLI/SRAI
                    case (bits[2:0])
                        3'b000:  salida_ALUcontrol = 4'b0000;
                        3'b001:  salida_ALUcontrol = 4'b1000;
                        3'b010:  salida_ALUcontrol = 4'b0100;
                        3'b011:  salida_ALUcontrol = 4'b1101;
                        3'b100:  salida_ALUcontrol = 4'b1001;
                        3'b101:  salida_ALUcontrol = bits[3] ? 4'b1110 : 4'b1010;
                        3'b110:  salida_ALUcontrol = 4'b0001;
                        default: salida_ALUcontrol = 4'b0010;
                    endcase
                end
                4'b0011: salida_ALUcontrol = 4'b1100;
                4'b1111: begin
                    case (bits[2:0])
                        3'b000:  salida_ALUcontrol = 4'b1111;
                        3'b001:  salida_ALUcontrol = 4'b0011;
                        3'b100:  salida_ALUcontrol = 4'b0100;
                        default: salida_ALUcontrol = 4'b0000;
                    endcase
                end
                default: salida_ALUcontrol = 4'b0000;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Operand conditioning at accept
    // ------------------------------------------------------------------
    logic             w_accept, w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic             w_div0, w_ovf;
    logic [2:0]       w_op;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;

    assign w_accept = (r_state == S_IDLE) && start && w_mop;
    assign w_op     = bits[2:0];
    assign w_is_div = w_op[2];
    // Signedness: MUL/MULH/MULHSU sign A, MUL/MULH sign B, DIV/REM sign both
    assign w_a_sgn  = w_is_div ? ~w_op[0] : (w_op != 3'b011);
    assign w_b_sgn  = w_is_div ? ~w_op[0] : ~w_op[1];
    assign w_a_neg  = w_a_sgn & A[WIDTH-1];
    assign w_b_neg  = w_b_sgn & B[WIDTH-1];
    // The most negative value maps onto itself, which is the correct unsigned magnitude
    assign w_a_mag  = w_a_neg ? -A : A;
    assign w_b_mag  = w_b_neg ? -B : B;
    assign w_div0   = (B == '0);
    assign w_ovf    = w_a_sgn && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (&B);

    // ------------------------------------------------------------------
    // Working registers
    //   r_prod: MUL -> {accumulator, multiplier}; DIV -> {remainder, dividend/quotient}
    //   r_opnd: MUL multiplicand magnitude or DIV divisor magnitude
    // ------------------------------------------------------------------
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_opnd, r_result;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_neg_q, r_neg_r, r_fast, r_div0;
    logic [CW-1:0]      r_cnt;

    logic                w_last;
    logic [WIDTH:0]      w_mul_sum, w_div_shift, w_div_diff;
    logic [2*WIDTH-1:0]  w_mul_next, w_div_next, w_prod_s;
    logic [WIDTH-1:0]    w_q, w_r, w_mul_res, w_div_res, w_fast_res;

    assign w_last      = (r_cnt == CW'(WIDTH - 1));

    assign w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next  = {w_mul_sum, r_prod[WIDTH-1:1]};
    assign w_prod_s    = r_neg_q ? -w_mul_next : w_mul_next;
    assign w_mul_res   = (r_op[1:0] == 2'b00) ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH];

    // Restoring step: bring the next dividend bit in, keep the difference if it did not borrow
    assign w_div_shift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
    assign w_div_next  = w_div_diff[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b0}
                       : {w_div_diff[WIDTH-1:0],  r_prod[WIDTH-2:0], 1'b1};
    assign w_q         = r_neg_q ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0];
    assign w_r         = r_neg_r ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];
    assign w_div_res   = r_op[1] ? w_r : w_q;

    // Divide by zero: q = all ones, r = A. Overflow: q = A, r = 0.
    assign w_fast_res  = r_op[1] ? (r_div0 ? r_a : '0) : (r_div0 ? '1 : r_a);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_is_div ? S_DIV : S_MUL;
            S_MUL:  if (w_last) w_next = S_DONE;
            S_DIV:  if (r_fast || w_last) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_op     <= '0;
            r_a      <= '0;
            r_opnd   <= '0;
            r_prod   <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_fast   <= 1'b0;
            r_div0   <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_op;
                        r_a     <= A;
                        r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
                        r_prod  <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_fast  <= w_is_div && (w_div0 || w_ovf);
                        r_div0  <= w_div0;
                        r_cnt   <= '0;
                    end
                end
                S_MUL: begin
                    r_prod <= w_mul_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) r_result <= w_mul_res;
                end
                S_DIV: begin
                    if (r_fast) begin
                        r_result <= w_fast_res;
                    end else begin
                        r_prod <= w_div_next;
                        r_cnt  <= r_cnt + 1'b1;
                        if (w_last) r_result <= w_div_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    // Held low in reset even though start may be high with an M-op present
    assign stall  = !RESET && (((r_state == S_IDLE) && start && w_mop) ||
                               (r_state == S_MUL) || (r_state == S_DIV));

endmodule

// File: tb/tb_alu_md_control.sv
module tb_alu_md_control;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [3:0]   ALUOp, bits;
    logic         m_sel, start;
    logic [W-1:0] A, B;
    logic [3:0]   salida_ALUcontrol;
    logic         stall, busy, done;
    logic [W-1:0] result;

    alu_md_control #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .ALUOp(ALUOp), .bits(bits), .m_sel(m_sel),
        .start(start), .A(A), .B(B), .salida_ALUcontrol(salida_ALUcontrol),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    string        name_q[$];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse consumes one expected result
    always @(negedge CLK) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %h expected no completion", result);
            end else begin
                chk({"result_", name_q.pop_front()}, result, exp_q.pop_front());
            end
        end
    end

    task automatic dec(input logic [3:0] op, input logic [3:0] b, input logic m, input logic [3:0] e);
        ALUOp = op; bits = b; m_sel = m;
        #1 chk($sformatf("decode_%b_%b_%b", op, b, m), W'(salida_ALUcontrol), W'(e));
    endtask

    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int lat, input string nm);
        int n, nb;
        @(negedge CLK);
        ALUOp = 4'b0000; m_sel = 1'b1; bits = {1'b0, op}; A = a; B = b; start = 1'b1;
        #1 chk({"stall_req_", nm}, W'(stall), W'(1));
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(posedge CLK);
        #1 start = 1'b0;
        // Scramble inputs: the op in flight must not see them
        A = $urandom; B = $urandom; bits = 4'($urandom); m_sel = 1'($urandom);
        n = 1; nb = 0;
        while (n < 100) begin
            @(negedge CLK);
            if (busy) nb++;
            if (done) break;
            @(posedge CLK);
            n++;
        end
        chk({"latency_", nm}, W'(n), W'(lat));
        chk({"busy_cycles_", nm}, W'(nb), W'(lat));
        chk({"stall_done_", nm}, W'(stall), W'(0));
        @(negedge CLK);
        chk({"done_drop_", nm}, W'({busy, done}), W'(0));
        chk({"result_hold_", nm}, result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; start = 1'b1; ALUOp = 4'b0000; m_sel = 1'b1; bits = 4'b0000;
        A = 32'd3; B = 32'd5;
        repeat (2) @(negedge CLK);
        chk("reset_busy",   W'(busy),  W'(0));
        chk("reset_done",   W'(done),  W'(0));
        chk("reset_stall",  W'(stall), W'(0));
        chk("reset_result", result,    '0);
        start = 1'b0;
        RESET = 1'b0;

        // Decode table
        dec(4'b0000, 4'b0000, 1'b0, 4'b0000);
        dec(4'b0000, 4'b1000, 1'b0, 4'b0111);
        dec(4'b0000, 4'b0001, 1'b0, 4'b1000);
        dec(4'b0000, 4'b0010, 1'b0, 4'b0100);
        dec(4'b0000, 4'b0011, 1'b0, 4'b0100);
        dec(4'b0000, 4'b0100, 1'b0, 4'b1001);
        dec(4'b0000, 4'b0101, 1'b0, 4'b1010);
        dec(4'b0000, 4'b1101, 1'b0, 4'b1110);
        dec(4'b0000, 4'b0110, 1'b0, 4'b0001);
        dec(4'b0000, 4'b0111, 1'b0, 4'b0010);
        dec(4'b0000, 4'b1001, 1'b0, 4'b0000);
        dec(4'b1100, 4'b1000, 1'b0, 4'b0000);
        dec(4'b1100, 4'b1001, 1'b0, 4'b1000);
        dec(4'b1100, 4'b0011, 1'b0, 4'b1101);
        dec(4'b1100, 4'b0101, 1'b0, 4'b1010);
        dec(4'b1100, 4'b1101, 1'b0, 4'b1110);
        dec(4'b1100, 4'b0111, 1'b0, 4'b0010);
        dec(4'b0001, 4'b0101, 1'b0, 4'b0000);
        dec(4'b0111, 4'b0011, 1'b0, 4'b0000);
        dec(4'b1110, 4'b0100, 1'b0, 4'b0000);
        dec(4'b0011, 4'b0000, 1'b0, 4'b1100);
        dec(4'b1111, 4'b0000, 1'b0, 4'b1111);
        dec(4'b1111, 4'b1001, 1'b0, 4'b0011);
        dec(4'b1111, 4'b0100, 1'b0, 4'b0100);
        dec(4'b1111, 4'b0010, 1'b0, 4'b0000);
        dec(4'b0101, 4'b0000, 1'b0, 4'b0000);
        dec(4'b0000, 4'b0100, 1'b1, 4'b0000);

        // start without an M-op is ignored
        @(negedge CLK);
        ALUOp = 4'b0000; m_sel = 1'b0; bits = 4'b0000; start = 1'b1;
        #1 chk("non_mop_stall", W'(stall), W'(0));
        @(negedge CLK);
        chk("non_mop_busy", W'(busy), W'(0));
        start = 1'b0;

        // M-ops
        do_op(3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul");
        do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
        do_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, "mulh");
        do_op(3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, "mulhsu");
        do_op(3'b000, 32'h12345678, 32'h10,       32'h23456780, 33, "mul_big");
        do_op(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, "div_neg");
        do_op(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, "rem_neg");
        do_op(3'b111, 32'd7,        32'd2,        32'h00000001, 33, "remu");
        do_op(3'b101, 32'd100,      32'd7,        32'd14,       33, "divu");
        do_op(3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33, "div_negb");
        do_op(3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        33, "rem_negb");
        do_op(3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 2,  "divu_by0");
        do_op(3'b110, 32'd5,        32'd0,        32'd5,        2,  "rem_by0");
        do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2,  "div_ovf");
        do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2,  "rem_ovf");

        // Reset in the middle of a MUL aborts it with no result
        @(negedge CLK);
        ALUOp = 4'b0000; m_sel = 1'b1; bits = 4'b0000; A = 32'd3; B = 32'd5; start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0; m_sel = 1'b0; bits = 4'b1101;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        chk("midop_busy_before", W'(busy), W'(1));
        chk("decode_before_reset", W'(salida_ALUcontrol), W'(4'b1110));
        RESET = 1'b1;
        #1;
        chk("midop_reset_busy",   W'(busy),  W'(0));
        chk("midop_reset_done",   W'(done),  W'(0));
        chk("midop_reset_result", result,    '0);
        chk("midop_reset_stall",  W'(stall), W'(0));
        chk("decode_in_reset",    W'(salida_ALUcontrol), W'(4'b1110));
        repeat (2) @(negedge CLK);
        chk("decode_in_reset2",   W'(salida_ALUcontrol), W'(4'b1110));
        RESET = 1'b0;
        repeat (40) @(negedge CLK);
        chk("post_reset_idle", W'({busy, done}), W'(0));

        do_op(3'b000, 32'd3, 32'd5, 32'd15, 33, "mul_fresh");

        repeat (3) @(negedge CLK);
        chk("scoreboard_empty", W'(exp_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
